// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller.
// One 1-bit full-add slice (two half adders) is reused across WIDTH RUN cycles
// to add two WIDTH-bit operands LSB first, under a start/busy/done handshake.
// sum/carry hold the last completed result until the next completion or reset.

// Single-bit half adder: the building block of the serial full-add slice.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Counter must be able to reach WIDTH after the last bit, so it never wraps.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_reg_q, carry_reg_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  // Bit-slice signals for the bit currently being processed.
  logic [WIDTH-1:0] bit_mask;
  logic             a_bit;
  logic             b_bit;
  logic             s0, c0;
  logic             s1, c1;
  logic             last_bit;

  // Select operand bit i = cnt_q with a one-hot mask, so every operand bit is
  // read and no out-of-range index is ever formed.
  always_comb begin
    bit_mask = WIDTH'(1) << cnt_q;
    a_bit    = |(opa_q & bit_mask);
    b_bit    = |(opb_q & bit_mask);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // ha0 adds the two operand bits; ha1 folds in the carry from the previous bit.
  halfadder ha0 (
    .a (a_bit),
    .b (b_bit),
    .s (s0),
    .c (c0)
  );

  halfadder ha1 (
    .a (s0),
    .b (carry_reg_q),
    .s (s1),
    .c (c1)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_reg_d = carry_reg_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    sum_d       = sum_q;
    carry_d     = carry_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d       = a;
          opb_d       = b;
          res_d       = '0;
          carry_reg_d = 1'b0;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        // Write the sum bit into position i of the partial result.
        res_d       = (res_q & ~bit_mask) | (s1 ? bit_mask : '0);
        carry_reg_d = c0 | c1;
        cnt_d       = cnt_q + CW'(1);
        if (last_bit) begin
          // Expose the result only when the final bit is known.
          sum_d   = res_d;
          carry_d = c0 | c1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and visible result registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_reg_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_reg_q <= carry_reg_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
    end
  end

  // Operand and partial-result registers.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are deliberately not reset; they are always
    // loaded on accept before use and never reach the outputs directly.
    opa_q <= opa_d;
    opb_q <= opb_d;
    res_q <= res_d;
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    busy  = (state_q == RUN) || (state_q == DONE);
    done  = (state_q == DONE);
    sum   = sum_q;
    carry = carry_q;
  end

endmodule
